// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB manager request port among NUM_REQ requesters.
// Round-robin by default; define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module apb_req_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    output logic [NUM_REQ-1:0]       done,
    output logic [31:0]              rdata_o,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     transfer,
    output logic                     write,
    output logic [31:0]              addr,
    output logic [31:0]              wdata,
    input  logic [31:0]              rdata,
    input  logic                     ready
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE, SETUP, ACCESS, DONE} state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q, done_q;
    logic                 busy_q, transfer_q, write_q;
    logic [31:0]          addr_q, wdata_q, rdata_q;
    logic [IW-1:0]        win_d;
`ifndef APB_ARB_FIXED_PRIO_EN
    logic [IW-1:0]        last_q, idx_q, rr_j;
`endif

`ifdef APB_ARB_FIXED_PRIO_EN
    always_comb begin
        win_d = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[k]) win_d = IW'(k);
    end
`else
    // Scan farthest-first so the nearest requester after last_q is the final write.
    always_comb begin
        win_d = '0;
        rr_j  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_j = IW'((int'(last_q) + k) % NUM_REQ);
            if (req[rr_j]) win_d = rr_j;
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            transfer_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_q     <= IW'(NUM_REQ - 1);
            idx_q      <= '0;
`endif
        end else begin
            transfer_q <= 1'b0;
            done_q     <= '0;
            case (state_q)
                IDLE: if (|req) begin
                    state_q        <= ISSUE;
                    grant_q[win_d] <= 1'b1;
                    busy_q         <= 1'b1;
                    transfer_q     <= 1'b1;
                    write_q        <= req_write[win_d];
                    addr_q         <= req_addr[win_d];
                    wdata_q        <= req_wdata[win_d];
`ifndef APB_ARB_FIXED_PRIO_EN
                    idx_q          <= win_d;
`endif
                end
                ISSUE:  state_q <= SETUP;
                SETUP:  state_q <= ACCESS;
                ACCESS: if (ready) begin
                    state_q <= DONE;
                    rdata_q <= rdata;
                    done_q  <= grant_q;
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    write_q <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
                    last_q  <= idx_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign rdata_o  = rdata_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign transfer = transfer_q;
    assign write    = write_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized checks of apb_req_arbiter against a transaction-level model.
module tb_apb_req_arbiter;
    localparam int N = 3;

    logic                 PCLK = 1'b0;
    logic                 PRESET = 1'b1;
    logic [N-1:0]         req = '0, req_write = '0;
    logic [N-1:0][31:0]   req_addr = '0, req_wdata = '0;
    logic [N-1:0]         done, grant;
    logic [31:0]          rdata_o, addr, wdata;
    logic                 busy, transfer, write;
    logic [31:0]          rdata = '0;
    logic                 ready = 1'b0;

    int          checks = 0, failures = 0;
    int          m_last = N - 1;
    logic [31:0] m_rdata = '0;

    apb_req_arbiter #(.NUM_REQ(N)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata_o(rdata_o),
        .grant(grant), .busy(busy), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: fixed priority picks the lowest set index; round-robin
    // picks the first set index scanning upward from last+1, wrapping mod N.
    function automatic int exp_win(input logic [N-1:0] m, input int last);
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (m[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic chk_owned(input string tag, input int w);
        chk({tag, "_grant"}, grant, 32'(1) << w);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_write"}, write, req_write[w]);
        chk({tag, "_addr"}, addr, req_addr[w]);
        chk({tag, "_wdata"}, wdata, req_wdata[w]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_transfer"}, transfer, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_rdata"}, rdata_o, m_rdata);
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic xfer(input logic [N-1:0] mask, input int waits, input bit rs, input bit early);
        int w;
        logic [31:0] val;
        w = exp_win(mask, m_last);
        val = $urandom;
        req = mask;
        ready = 1'b0;
        step();
        chk("issue_transfer", transfer, 1);
        chk("issue_done", done, 0);
        chk("issue_rdata_hold", rdata_o, m_rdata);
        chk_owned("issue", w);
        if (early) req[w] = 1'b0;
        step();
        chk("setup_transfer", transfer, 0);
        chk("setup_done", done, 0);
        chk_owned("setup", w);
        ready = rs;
        rdata = $urandom;
        for (int i = 0; i <= waits; i++) begin
            step();
            chk("access_transfer", transfer, 0);
            chk("access_done", done, 0);
            chk("access_rdata_hold", rdata_o, m_rdata);
            chk_owned("access", w);
            ready = (i == waits);
            rdata = (i == waits) ? val : $urandom;
        end
        step();
        chk("done_pulse", done, 32'(1) << w);
        chk("done_transfer", transfer, 0);
        chk("done_rdata", rdata_o, val);
        chk_owned("done", w);
        m_rdata = val;
        m_last = w;
        req[w] = 1'b0;
        ready = 1'b0;
        step();
        chk_idle("idle");
    endtask

    initial begin
        logic [N-1:0] mask;
        step();
        step();
        chk_idle("reset");
        PRESET = 1'b0;
        step();
        chk_idle("post_reset");

        req_write[0] = 1'b1; req_addr[0] = 32'h1000_1004; req_wdata[0] = 32'hDEAD_BEEF;
        xfer(3'b001, 0, 1'b0, 1'b0);

        req_write[1] = 1'b0; req_addr[1] = 32'h1000_0010; req_wdata[1] = 32'h0;
        xfer(3'b010, 3, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) xfer(3'b011, 0, 1'b0, 1'b0);

        req_write[2] = 1'b0; req_addr[2] = 32'h2000_0000; req_wdata[2] = 32'h5;
        xfer(3'b100, 2, 1'b1, 1'b0);
        xfer(3'b001, 1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) if (!req[i]) begin
                req_write[i] = 1'($urandom);
                req_addr[i]  = $urandom;
                req_wdata[i] = $urandom;
            end
            mask = req | N'($urandom_range(1, (1 << N) - 1));
            xfer(mask, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        req = 3'b001;
        step();
        req = '0;
        step();
        step();
        chk("pre_reset_busy", busy, 1);
        PRESET = 1'b1;
        step();
        m_rdata = '0;
        m_last = N - 1;
        chk_idle("mid_reset");
        PRESET = 1'b0;
        step();
        chk_idle("mid_reset_after");
        xfer(3'b011, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the APB_Manager internal port (legal 2..4).
REQ-002 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 req  input  NUM_REQ  per-requester transfer request; held high until own done pulse.
REQ-005 req_write  input  NUM_REQ  per-requester direction, 1 = write; stable while req high.
REQ-006 req_addr  input  NUM_REQ x 32  per-requester address; stable while req high.
REQ-007 req_wdata  input  NUM_REQ x 32  per-requester write data; stable while req high.
REQ-008 done  output  NUM_REQ  one-hot, one-cycle completion pulse to granted requester.
REQ-009 rdata_o  output  32  read data captured at completion; valid in done cycle and held until next completion.
REQ-010 grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 transfer, write, addr[31:0], wdata[31:0]  output  manager-side request port.
REQ-013 rdata[31:0], ready  input  manager-side response port.

Function
REQ-014 FSM states IDLE, ISSUE, SETUP, ACCESS, DONE; all transitions registered.
REQ-015 IDLE: if any req bit high, register winner into grant, go ISSUE; else stay.
REQ-016 ISSUE: transfer = 1 for exactly this cycle; go SETUP.
REQ-017 SETUP: transfer = 0; ready ignored (manager in its SETUP phase); go ACCESS.
REQ-018 ACCESS: transfer = 0; on ready = 1 capture rdata into rdata_o, go DONE; else stay (wait states unbounded).
REQ-019 DONE: done bit of granted requester = 1 for one cycle; update last-grant pointer; clear grant; go IDLE.
REQ-020 write/addr/wdata = granted requester's fields in ISSUE, SETUP, ACCESS, DONE; all zero in IDLE.
REQ-021 transfer never asserted outside ISSUE; manager always returns to its IDLE between transfers.
REQ-022 Zero-wait latency: req seen in IDLE at cycle 0 -> transfer at cycle 1 -> ready sampled cycle 3 -> done cycle 4; each slave wait state adds one cycle.
REQ-023 Minimum spacing: next ISSUE no earlier than 2 cycles after DONE (IDLE then ISSUE).
REQ-024 Round-robin: search starts at (last_grant + 1) mod NUM_REQ; first high req wins.
REQ-025 Req deassertion before done (protocol violation): transfer still completes; done still pulses.
REQ-026 req high again after done: treated as new request, arbitrated normally in IDLE.
REQ-027 rdata_o updated only on ACCESS with ready = 1; write transfers also capture rdata (value don't-care).

Reset
REQ-028 PRESET high at rising edge: state = IDLE, grant = 0, done = 0, busy = 0, transfer = 0, write = 0, addr = 0, wdata = 0, rdata_o = 0, last_grant = NUM_REQ-1.
REQ-029 Reset mid-transfer abandons transfer without done pulse; PRESET shared with APB_Manager.

Configuration
REQ-030 Macro APB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, last_grant unused.
REQ-031 Macro APB_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-024.

Verification
REQ-032 req[0] write addr 32'h1000_1004 wdata 32'hDEAD_BEEF, zero-wait slave -> transfer cycle 1 only, done[0] cycle 4, addr/wdata stable cycles 1-4.
REQ-033 req[1] read 32'h1000_0010, slave returns 32'h1234_5678 after 3 wait states -> done[1] cycle 7, rdata_o = 32'h1234_5678.
REQ-034 req = 2'b11 held, round-robin -> grants 0,1,0,1 each separated by one IDLE cycle; fixed-prio build -> requester 0 only while held.
REQ-035 ready forced high during SETUP -> ignored; done only after ACCESS ready.
REQ-036 PRESET in ACCESS -> next cycle all outputs zero, no done pulse, next req grants requester 0.
